// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared register-file widths and the writeback entry type
package riscv_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_entry_t;

endpackage

// File: rtl/wb_lookup_match.sv
// rtl/wb_lookup_match.sv - youngest-match search over pending writeback entries
// Ports:
//   entries  - queue storage, physical slot order
//   valid    - per-slot occupancy mask
//   head     - slot index of the oldest queued entry
//   wb_entry - entry currently held in the write-port register
//   wb_valid - write-port register holds a live write
//   lk_addr  - register being looked up
//   hit      - a pending write to lk_addr exists
//   data     - value of the youngest such write, 0 when no hit
module wb_lookup_match
    import riscv_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  wb_entry_t [DEPTH-1:0]         entries,
    input  logic [DEPTH-1:0]              valid,
    input  logic [$clog2(DEPTH)-1:0]      head,
    input  wb_entry_t                     wb_entry,
    input  logic                          wb_valid,
    input  logic [REG_AW-1:0]             lk_addr,
    output logic                          hit,
    output logic [XLEN-1:0]               data
);

    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0] idx;

    // Walk from oldest (write-port register) to youngest (tail side);
    // each later match overrides, so the youngest value wins.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        if (lk_addr != '0) begin
            if (wb_valid && wb_entry.rd == lk_addr) begin
                hit  = 1'b1;
                data = wb_entry.data;
            end
            for (int i = 0; i < DEPTH; i++) begin
                idx = head + PW'(i);
                if (valid[idx] && entries[idx].rd == lk_addr) begin
                    hit  = 1'b1;
                    data = entries[idx].data;
                end
            end
        end
    end

endmodule

// File: rtl/regfile_wb_buffer.sv
// rtl/regfile_wb_buffer.sv - dual-port writeback queue feeding the register-file write port
// Ports:
//   clk, srst             - clock, synchronous active-high reset
//   in0_valid/rd/data     - ALU result input, in0_ready handshake
//   in1_valid/rd/data     - load/multi-cycle result input, in1_ready handshake
//   wb_we/wb_addr/wb_data - registered register-file write port (WE3/A3/WD3)
//   lk_addr/lk_hit/lk_data- combinational pending-write lookup
//   count                 - queued entries, excluding the write-port register
module regfile_wb_buffer
    import riscv_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      srst,
    input  logic                      in0_valid,
    input  logic [REG_AW-1:0]         in0_rd,
    input  logic [XLEN-1:0]           in0_data,
    output logic                      in0_ready,
    input  logic                      in1_valid,
    input  logic [REG_AW-1:0]         in1_rd,
    input  logic [XLEN-1:0]           in1_data,
    output logic                      in1_ready,
    output logic                      wb_we,
    output logic [REG_AW-1:0]         wb_addr,
    output logic [XLEN-1:0]           wb_data,
    input  logic [REG_AW-1:0]         lk_addr,
    output logic                      lk_hit,
    output logic [XLEN-1:0]           lk_data,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wb_entry_t [DEPTH-1:0] mem;
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         wr_ptr;
    logic [CW-1:0]         count_q;
    logic                  pop;
    logic [CW:0]           free;
    logic                  push0;
    logic                  push1;
    logic [DEPTH-1:0]      slot_valid;
    logic [PW-1:0]         offs;
    logic                  match_hit;
    logic [XLEN-1:0]       match_data;

    assign count = count_q;
    assign pop   = (count_q != '0);

    // The head pops on the same edge that accepts new entries, so an occupied
    // queue offers one more slot than it visibly has.
    always_comb begin
        free      = (CW+1)'(DEPTH) - {1'b0, count_q} + {{CW{1'b0}}, pop};
        in0_ready = 1'b0;
        in1_ready = 1'b0;
        if (!srst) begin
            if (free >= (CW+1)'(2)) begin
                in0_ready = 1'b1;
                in1_ready = 1'b1;
            end else if (free == (CW+1)'(1)) begin
                in1_ready = 1'b1;
                in0_ready = !in1_valid;
            end
        end
    end

    // Writes to x0 complete the handshake but are discarded here.
    assign push1 = in1_valid && in1_ready && (in1_rd != '0);
    assign push0 = in0_valid && in0_ready && (in0_rd != '0);

    // Port 1 is the older of two same-cycle results, so it takes the lower slot.
    always_ff @(posedge clk) begin
        if (push1) mem[wr_ptr] <= '{rd: in1_rd, data: in1_data};
        if (push0) mem[wr_ptr + PW'(push1)] <= '{rd: in0_rd, data: in0_data};
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
            wb_we   <= 1'b0;
            wb_addr <= '0;
            wb_data <= '0;
        end else begin
            if (pop) begin
                wb_we   <= 1'b1;
                wb_addr <= mem[rd_ptr].rd;
                wb_data <= mem[rd_ptr].data;
                rd_ptr  <= rd_ptr + PW'(1);
            end else begin
                wb_we   <= 1'b0;
            end
            wr_ptr  <= wr_ptr + PW'(push0) + PW'(push1);
            count_q <= count_q + CW'(push0) + CW'(push1) - CW'(pop);
        end
    end

    // A slot is live when its distance from the head is below the fill level.
    always_comb begin
        offs = '0;
        for (int j = 0; j < DEPTH; j++) begin
            offs          = PW'(j) - rd_ptr;
            slot_valid[j] = ({1'b0, offs} < count_q);
        end
    end

    wb_lookup_match #(.DEPTH(DEPTH)) u_match (
        .entries  (mem),
        .valid    (slot_valid),
        .head     (rd_ptr),
        .wb_entry ('{rd: wb_addr, data: wb_data}),
        .wb_valid (wb_we),
        .lk_addr  (lk_addr),
        .hit      (match_hit),
        .data     (match_data)
    );

    assign lk_hit  = match_hit && !srst;
    assign lk_data = srst ? '0 : match_data;

endmodule

// File: tb/tb_regfile_wb_buffer.sv
// tb/tb_regfile_wb_buffer.sv - scoreboard bench for regfile_wb_buffer
module tb_regfile_wb_buffer;

    logic        clk = 1'b0;
    logic        srst;
    logic        in0_valid, in1_valid;
    logic [4:0]  in0_rd, in1_rd;
    logic [31:0] in0_data, in1_data;
    logic        in0_ready, in1_ready;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [4:0]  lk_addr;
    logic        lk_hit;
    logic [31:0] lk_data;
    logic [2:0]  count;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] rf [32];
    logic [36:0] exp_q [$];
    logic [36:0] mon_e;
    logic        last_a0, last_a1;

    int exp_a0  [6] = '{1, 1, 1, 0, 0, 0};
    int exp_cnt [6] = '{2, 3, 4, 4, 4, 4};

    always #5 clk = ~clk;

    regfile_wb_buffer #(.DEPTH(4)) dut (
        .clk       (clk),
        .srst      (srst),
        .in0_valid (in0_valid),
        .in0_rd    (in0_rd),
        .in0_data  (in0_data),
        .in0_ready (in0_ready),
        .in1_valid (in1_valid),
        .in1_rd    (in1_rd),
        .in1_data  (in1_data),
        .in1_ready (in1_ready),
        .wb_we     (wb_we),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .lk_addr   (lk_addr),
        .lk_hit    (lk_hit),
        .lk_data   (lk_data),
        .count     (count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at a negedge: drive for the coming posedge, log accepted
    // nonzero-rd results (port 1 first), and return at the next negedge.
    task automatic step(input logic v0, input logic [4:0] r0, input logic [31:0] d0,
                        input logic v1, input logic [4:0] r1, input logic [31:0] d1);
        in0_valid = v0; in0_rd = r0; in0_data = d0;
        in1_valid = v1; in1_rd = r1; in1_data = d1;
        #1;
        last_a1 = v1 && in1_ready;
        last_a0 = v0 && in0_ready;
        if (last_a1 && r1 != 5'd0) exp_q.push_back({r1, d1});
        if (last_a0 && r0 != 5'd0) exp_q.push_back({r0, d0});
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    always @(negedge clk) begin
        if (wb_we === 1'b1) begin
            rf[wb_addr] = wb_data;
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL wb_unexpected: got write x%0d=0x%0h expected no write", wb_addr, wb_data);
            end else begin
                mon_e = exp_q.pop_front();
                chk("sb_wb_addr", {27'd0, wb_addr}, {27'd0, mon_e[36:32]});
                chk("sb_wb_data", wb_data, mon_e[31:0]);
            end
        end
    end

    initial begin
        #200000;
        fails++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        srst = 1'b1;
        in0_valid = 1'b0; in0_rd = '0; in0_data = '0;
        in1_valid = 1'b0; in1_rd = '0; in1_data = '0;
        lk_addr = 5'd5;
        for (int i = 0; i < 32; i++) rf[i] = '0;
        repeat (2) @(negedge clk);

        chk("rst_wb_we",   wb_we, 0);
        chk("rst_wb_addr", wb_addr, 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_count",   count, 0);
        chk("rst_in0_rdy", in0_ready, 0);
        chk("rst_in1_rdy", in1_ready, 0);
        chk("rst_lk_hit",  lk_hit, 0);
        srst = 1'b0;

        // single write
        step(1'b1, 5'd5, 32'h5, 1'b0, 5'd0, 32'd0);
        chk("single_count_q", count, 1);
        chk("single_we_early", wb_we, 0);
        chk("single_lk_hit_q", lk_hit, 1);
        chk("single_lk_data_q", lk_data, 32'h5);
        idle();
        chk("single_we", wb_we, 1);
        chk("single_addr", wb_addr, 5);
        chk("single_data", wb_data, 32'h5);
        chk("single_count_0", count, 0);
        chk("single_lk_hit_wb", lk_hit, 1);
        idle();
        chk("single_we_once", wb_we, 0);
        chk("single_rf_x5", rf[5], 32'h5);
        chk("single_lk_gone", lk_hit, 0);

        // dual accept ordering
        lk_addr = 5'd9;
        step(1'b1, 5'd9, 32'hA, 1'b1, 5'd9, 32'h8);
        chk("dual_a0", last_a0, 1);
        chk("dual_a1", last_a1, 1);
        chk("dual_count", count, 2);
        chk("dual_lk_hit", lk_hit, 1);
        chk("dual_lk_young", lk_data, 32'hA);
        idle();
        chk("dual_first", wb_data, 32'h8);
        chk("dual_lk_mid", lk_data, 32'hA);
        idle();
        chk("dual_second", wb_data, 32'hA);
        chk("dual_lk_wb", lk_data, 32'hA);
        idle();

        // x0 filter
        lk_addr = 5'd0;
        step(1'b1, 5'd0, 32'hDEAD, 1'b0, 5'd0, 32'd0);
        chk("x0_ready", last_a0, 1);
        chk("x0_count", count, 0);
        chk("x0_lk_hit", lk_hit, 0);
        chk("x0_lk_data", lk_data, 0);
        idle();
        chk("x0_no_we", wb_we, 0);

        // backpressure: two offers per cycle
        for (int s = 0; s < 6; s++) begin
            step(1'b1, 5'(s + 10), 32'h100 + 32'(s), 1'b1, 5'(s + 20), 32'h200 + 32'(s));
            chk("bp_in0_accept", {31'd0, last_a0}, 32'(exp_a0[s]));
            chk("bp_in1_accept", last_a1, 1);
            chk("bp_count", count, 32'(exp_cnt[s]));
        end
        for (int c = 0; c < 20 && (exp_q.size() != 0 || count != 3'd0); c++) idle();
        chk("bp_drained_q", exp_q.size(), 0);
        chk("bp_drained_count", count, 0);
        idle();
        chk("bp_idle_we", wb_we, 0);

        // reset mid-stream drops queued x3/x4
        lk_addr = 5'd3;
        step(1'b1, 5'd4, 32'h44, 1'b1, 5'd3, 32'h33);
        chk("rstm_count", count, 2);
        chk("rstm_lk_pre", lk_data, 32'h33);
        srst = 1'b1;
        in0_valid = 1'b1; in0_rd = 5'd7; in0_data = 32'h77;
        in1_valid = 1'b1; in1_rd = 5'd7; in1_data = 32'h78;
        #1;
        exp_q.delete();
        chk("rstm_in0_rdy", in0_ready, 0);
        chk("rstm_in1_rdy", in1_ready, 0);
        chk("rstm_lk_srst", lk_hit, 0);
        @(negedge clk);
        chk("rstm_we", wb_we, 0);
        chk("rstm_count0", count, 0);
        srst = 1'b0;
        idle();
        chk("rstm_lk_after", lk_hit, 0);
        chk("rstm_we_after", wb_we, 0);
        repeat (3) idle();
        chk("rstm_rf_x3", rf[3], 0);
        chk("rstm_rf_x4", rf[4], 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
